// File: rtl/fetch_stage_if.sv
// Signal bundle between the fetch stage, instruction memory and decode.
// The master side is the fetch stage; the slave side is the memory/pipeline environment.
interface fetch_stage_if #(
   parameter int unsigned PC_W    = 64,
   parameter int unsigned INSTR_W = 32
);
   logic               stall;
   logic               branch_taken;
   logic [PC_W-1:0]    branch_target;
   logic [PC_W-1:0]    imem_addr;
   logic [INSTR_W-1:0] imem_rdata;
   logic [PC_W-1:0]    ifid_pc;
   logic [INSTR_W-1:0] ifid_instr;
   logic               ifid_valid;

   modport master (
      input  stall, branch_taken, branch_target, imem_rdata,
      output imem_addr, ifid_pc, ifid_instr, ifid_valid
   );

   modport slave (
      output stall, branch_taken, branch_target, imem_rdata,
      input  imem_addr, ifid_pc, ifid_instr, ifid_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, pairs synchronous imem responses with their PC,
// and feeds the IF/ID register through a one-entry skid buffer that absorbs decode stalls.
module fetch_stage #(
   parameter int unsigned          PC_W      = 64,
   parameter int unsigned          INSTR_W   = 32,
   parameter logic [PC_W-1:0]      RESET_PC  = '0,
   parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
   input logic              clk,
   input logic              reset,
   fetch_stage_if.master    bus
);
   localparam logic [PC_W-1:0] PcStep = PC_W'(4);

   logic [PC_W-1:0]    pc_q, pc_d;
   logic               req_valid_q, req_valid_d;
   logic [PC_W-1:0]    req_pc_q, req_pc_d;
   logic               skid_valid_q, skid_valid_d;
   logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic               ifid_valid_q, ifid_valid_d;
   logic [PC_W-1:0]    ifid_pc_q, ifid_pc_d;
   logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;

   always_comb begin
      pc_d         = pc_q;
      req_valid_d  = req_valid_q;
      req_pc_d     = req_pc_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;

      if (bus.branch_taken) begin
         // Redirect wins over stall: drop the in-flight response and any skid entry.
         pc_d         = bus.branch_target;
         req_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         ifid_valid_d = 1'b0;
         ifid_instr_d = NOP_INSTR;
      end else if (bus.stall) begin
         // Re-presenting the held address is not a new request.
         req_valid_d = 1'b0;
         if (req_valid_q && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = req_pc_q;
            skid_instr_d = bus.imem_rdata;
         end
      end else begin
         if (skid_valid_q) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = skid_pc_q;
            ifid_instr_d = skid_instr_q;
         end else if (req_valid_q) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = req_pc_q;
            ifid_instr_d = bus.imem_rdata;
         end else begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
         end
         skid_valid_d = 1'b0;
         req_valid_d  = 1'b1;
         req_pc_d     = pc_q;
         pc_d         = pc_q + PcStep;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         req_valid_q  <= 1'b0;
         req_pc_q     <= '0;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_instr_q <= NOP_INSTR;
      end else begin
         pc_q         <= pc_d;
         req_valid_q  <= req_valid_d;
         req_pc_q     <= req_pc_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
      end
   end

   assign bus.imem_addr  = pc_q;
   assign bus.ifid_valid = ifid_valid_q;
   assign bus.ifid_pc    = ifid_pc_q;
   assign bus.ifid_instr = ifid_instr_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free-run, stall/skid, branch, branch+stall, PC wrap, reset.
module tb_fetch_stage;
   localparam int unsigned PC_W    = 64;
   localparam int unsigned INSTR_W = 32;
   localparam logic [INSTR_W-1:0] Nop    = 32'h0000_0013;
   localparam logic [PC_W-1:0]    WrapPc = 64'hFFFF_FFFF_FFFF_FFF8;

   logic clk = 1'b0;
   logic reset;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();
   fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus_w ();

   fetch_stage #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC('0), .NOP_INSTR(Nop)
   ) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   fetch_stage #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(WrapPc), .NOP_INSTR(Nop)
   ) u_dut_wrap (
      .clk(clk), .reset(reset), .bus(bus_w)
   );

   // Synchronous-read memories: word content equals its address.
   always @(posedge clk) bus.imem_rdata   <= bus.imem_addr[INSTR_W-1:0];
   always @(posedge clk) bus_w.imem_rdata <= bus_w.imem_addr[INSTR_W-1:0];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic expect_ifid(input string tag, input logic v, input logic [63:0] pc);
      check({tag, ".valid"}, 64'(bus.ifid_valid), 64'(v));
      if (v) begin
         check({tag, ".pc"}, bus.ifid_pc, pc);
         check({tag, ".instr"}, 64'(bus.ifid_instr), 64'(pc[31:0]));
      end else begin
         check({tag, ".instr"}, 64'(bus.ifid_instr), 64'(Nop));
      end
   endtask

   task automatic expect_wrap(input string tag, input logic [63:0] pc);
      check({tag, ".valid"}, 64'(bus_w.ifid_valid), 64'd1);
      check({tag, ".pc"}, bus_w.ifid_pc, pc);
      check({tag, ".instr"}, 64'(bus_w.ifid_instr), 64'(pc[31:0]));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      bus.stall = 1'b0;         bus.branch_taken = 1'b0;   bus.branch_target = '0;
      bus_w.stall = 1'b0;       bus_w.branch_taken = 1'b0; bus_w.branch_target = '0;
      repeat (2) step();
      check("rst.valid", 64'(bus.ifid_valid), 64'd0);
      check("rst.pc", bus.ifid_pc, 64'd0);
      check("rst.instr", 64'(bus.ifid_instr), 64'(Nop));
      check("rst.addr", bus.imem_addr, 64'd0);
      check("rst.addr_wrap", bus_w.imem_addr, WrapPc);

      // Free run
      reset = 1'b0;
      step();
      expect_ifid("run0", 1'b0, 64'd0);
      check("wrap0.valid", 64'(bus_w.ifid_valid), 64'd0);
      step(); expect_ifid("run1", 1'b1, 64'd0);  expect_wrap("wrap1", WrapPc);
      step(); expect_ifid("run2", 1'b1, 64'd4);  expect_wrap("wrap2", 64'hFFFF_FFFF_FFFF_FFFC);
      step(); expect_ifid("run3", 1'b1, 64'd8);  expect_wrap("wrap3", 64'd0);

      // Three-cycle stall while 8 is in IF/ID
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_ifid("stall_hold", 1'b1, 64'd8);
         if (i == 0) expect_wrap("wrap4", 64'd4);
      end
      bus.stall = 1'b0;
      step(); expect_ifid("rel0", 1'b1, 64'd12);
      step(); expect_ifid("rel1", 1'b1, 64'd16);

      // Branch to 0x100 while 16 is in IF/ID
      bus.branch_taken = 1'b1; bus.branch_target = 64'h100;
      step(); expect_ifid("br_bub0", 1'b0, 64'd0);
      check("br_bub0.pc_hold", bus.ifid_pc, 64'd16);
      bus.branch_taken = 1'b0;
      step(); expect_ifid("br_bub1", 1'b0, 64'd0);
      step(); expect_ifid("br_t0", 1'b1, 64'h100);
      step(); expect_ifid("br_t1", 1'b1, 64'h104);

      // Fill the skid, then branch+stall to 0x200
      bus.stall = 1'b1;
      step(); expect_ifid("bs_hold", 1'b1, 64'h104);
      bus.branch_taken = 1'b1; bus.branch_target = 64'h200;
      step(); expect_ifid("bs_bub0", 1'b0, 64'd0);
      bus.branch_taken = 1'b0; bus.stall = 1'b0;
      step(); expect_ifid("bs_bub1", 1'b0, 64'd0);
      step(); expect_ifid("bs_t0", 1'b1, 64'h200);
      step(); expect_ifid("bs_t1", 1'b1, 64'h204);

      // Reset mid-stream with the skid full and stall held
      bus.stall = 1'b1;
      step(); expect_ifid("rs_hold", 1'b1, 64'h204);
      reset = 1'b1;
      step();
      check("rs.valid", 64'(bus.ifid_valid), 64'd0);
      check("rs.pc", bus.ifid_pc, 64'd0);
      check("rs.instr", 64'(bus.ifid_instr), 64'(Nop));
      check("rs.addr", bus.imem_addr, 64'd0);
      reset = 1'b0; bus.stall = 1'b0;
      step(); expect_ifid("rr0", 1'b0, 64'd0);
      step(); expect_ifid("rr1", 1'b1, 64'd0);
      step(); expect_ifid("rr2", 1'b1, 64'd4);
      step(); expect_ifid("rr3", 1'b1, 64'd8);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
